// File: rtl/conv_stream_feeder.sv
`timescale 1ns/1ps
// conv_stream_feeder
// Holds one N-sample x vector and one M-tap f vector, loaded over a byte-wide
// load port. On start it replays both vectors num_iters times on two
// independent valid/ready streams that feed the convolver x and f inputs.
// Optional build macro: CONV_FEEDER_STALL_CNT_EN adds the stall_cycles output.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | buffers loadable/clearable, streams idle, waiting for start
// S_STREAM | replaying x and f frames, load port closed
module conv_stream_feeder #(
    parameter int N  = 128,
    parameter int M  = 32,
    parameter int W  = 8,
    parameter int IW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic          ld_sel,
    input  logic [W-1:0]  ld_data,
    input  logic          clear,
    input  logic          start,
    input  logic [IW-1:0] num_iters,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  m_data_x,
    output logic          m_valid_x,
    input  logic          m_ready_x,
    output logic [W-1:0]  m_data_f,
    output logic          m_valid_f,
    input  logic          m_ready_f
`ifdef CONV_FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cycles
`endif
);

    // index widths address the buffers, count widths must also hold N / M
    localparam int XAW = (N > 1) ? $clog2(N) : 1;
    localparam int XCW = $clog2(N + 1);
    localparam int FAW = (M > 1) ? $clog2(M) : 1;
    localparam int FCW = $clog2(M + 1);

    localparam logic [XCW-1:0] N_CNT  = XCW'(N);
    localparam logic [FCW-1:0] M_CNT  = FCW'(M);
    localparam logic [XAW-1:0] N_LAST = XAW'(N - 1);
    localparam logic [FAW-1:0] M_LAST = FAW'(M - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t          state;
    logic [W-1:0]    x_mem [N];
    logic [W-1:0]    f_mem [M];
    logic [XCW-1:0]  x_wr;
    logic [FCW-1:0]  f_wr;
    logic [XAW-1:0]  x_rd;
    logic [FAW-1:0]  f_rd;
    logic [IW-1:0]   x_iter;
    logic [IW-1:0]   f_iter;
    logic [IW-1:0]   iters;
    logic            x_fin;
    logic            f_fin;

    logic            loaded;
    logic            ld_fire;
    logic            start_ok;
    logic            x_hs;
    logic            f_hs;
    logic            x_last;
    logic            f_last;
    logic            x_last_frame;
    logic            f_last_frame;
    logic            x_fin_nx;
    logic            f_fin_nx;
    logic            all_fin;
    logic [XAW-1:0]  x_rd_inc;
    logic [FAW-1:0]  f_rd_inc;

    assign loaded   = (x_wr == N_CNT) && (f_wr == M_CNT);
    assign busy     = (state == S_STREAM);

    // ld_ready is gated by reset so the port reads closed while reset is held
    assign ld_ready = reset && (state == S_IDLE) && !clear &&
                      (ld_sel ? (f_wr < M_CNT) : (x_wr < N_CNT));
    assign ld_fire  = ld_valid && ld_ready;

    assign start_ok = (state == S_IDLE) && start && !clear && loaded;

    assign x_hs         = m_valid_x && m_ready_x;
    assign f_hs         = m_valid_f && m_ready_f;
    assign x_last       = (x_rd == N_LAST);
    assign f_last       = (f_rd == M_LAST);
    assign x_last_frame = (x_iter == (iters - IW'(1)));
    assign f_last_frame = (f_iter == (iters - IW'(1)));
    assign x_fin_nx     = x_fin || (x_hs && x_last && x_last_frame);
    assign f_fin_nx     = f_fin || (f_hs && f_last && f_last_frame);
    assign all_fin      = (state == S_STREAM) && x_fin_nx && f_fin_nx;
    assign x_rd_inc     = x_rd + XAW'(1);
    assign f_rd_inc     = f_rd + FAW'(1);

    // sample buffers: plain storage, contents survive done and clear
    always_ff @(posedge clk) begin
        if (ld_fire && !ld_sel) begin
            x_mem[x_wr[XAW-1:0]] <= ld_data;
        end
        if (ld_fire && ld_sel) begin
            f_mem[f_wr[FAW-1:0]] <= ld_data;
        end
    end

    // write pointers: advance on accepted load words, rewind on clear in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_wr <= '0;
            f_wr <= '0;
        end else if ((state == S_IDLE) && clear) begin
            x_wr <= '0;
            f_wr <= '0;
        end else if (ld_fire) begin
            if (ld_sel) begin
                f_wr <= f_wr + FCW'(1);
            end else begin
                x_wr <= x_wr + XCW'(1);
            end
        end
    end

    // control FSM with both registered output streams
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            iters     <= IW'(1);
            x_rd      <= '0;
            f_rd      <= '0;
            x_iter    <= '0;
            f_iter    <= '0;
            x_fin     <= 1'b0;
            f_fin     <= 1'b0;
            m_valid_x <= 1'b0;
            m_valid_f <= 1'b0;
            m_data_x  <= '0;
            m_data_f  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state     <= S_STREAM;
                        iters     <= (num_iters == '0) ? IW'(1) : num_iters;
                        x_rd      <= '0;
                        f_rd      <= '0;
                        x_iter    <= '0;
                        f_iter    <= '0;
                        x_fin     <= 1'b0;
                        f_fin     <= 1'b0;
                        m_valid_x <= 1'b1;
                        m_valid_f <= 1'b1;
                        m_data_x  <= x_mem[0];
                        m_data_f  <= f_mem[0];
                    end
                end
                S_STREAM: begin
                    if (x_hs) begin
                        if (!x_last) begin
                            x_rd     <= x_rd_inc;
                            m_data_x <= x_mem[x_rd_inc];
                        end else if (!x_last_frame) begin
                            x_rd     <= '0;
                            x_iter   <= x_iter + IW'(1);
                            m_data_x <= x_mem[0];
                        end else begin
                            m_valid_x <= 1'b0;
                            x_fin     <= 1'b1;
                        end
                    end
                    if (f_hs) begin
                        if (!f_last) begin
                            f_rd     <= f_rd_inc;
                            m_data_f <= f_mem[f_rd_inc];
                        end else if (!f_last_frame) begin
                            f_rd     <= '0;
                            f_iter   <= f_iter + IW'(1);
                            m_data_f <= f_mem[0];
                        end else begin
                            m_valid_f <= 1'b0;
                            f_fin     <= 1'b1;
                        end
                    end
                    if (all_fin) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CONV_FEEDER_STALL_CNT_EN
    // count STREAM cycles where either stream is back-pressured, saturating
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (start_ok) begin
            stall_cycles <= '0;
        end else if ((state == S_STREAM) &&
                     ((m_valid_x && !m_ready_x) || (m_valid_f && !m_ready_f)) &&
                     (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_stream_feeder.sv
`timescale 1ns/1ps
// Directed bench for conv_stream_feeder: load, replay, back-pressure,
// clear/start priority, and mid-stream reset.
module tb_conv_stream_feeder;

    localparam int N  = 128;
    localparam int M  = 32;
    localparam int W  = 8;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic          ld_sel = 1'b0;
    logic [W-1:0]  ld_data = '0;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic [IW-1:0] num_iters = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  m_data_x;
    logic          m_valid_x;
    logic          m_ready_x = 1'b1;
    logic [W-1:0]  m_data_f;
    logic          m_valid_f;
    logic          m_ready_f = 1'b1;
`ifdef CONV_FEEDER_STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] xv [N];
    logic [W-1:0] fv [M];

    conv_stream_feeder #(.N(N), .M(M), .W(W), .IW(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_sel    (ld_sel),
        .ld_data   (ld_data),
        .clear     (clear),
        .start     (start),
        .num_iters (num_iters),
        .busy      (busy),
        .done      (done),
        .m_data_x  (m_data_x),
        .m_valid_x (m_valid_x),
        .m_ready_x (m_ready_x),
        .m_data_f  (m_data_f),
        .m_valid_f (m_valid_f),
        .m_ready_f (m_ready_f)
`ifdef CONV_FEEDER_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic sel, input logic [W-1:0] data);
        ld_sel   = sel;
        ld_data  = data;
        ld_valid = 1'b1;
        #1;
        chk(sel ? "ld_ready_f" : "ld_ready_x", ld_ready, 1);
        step();
        ld_valid = 1'b0;
    endtask

    task automatic start_pulse(input int iters);
        num_iters = IW'(iters);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called right after start_pulse; follows both streams to done.
    task automatic run_stream(input string tag, input int frames, input bit rnd, input bit poke);
        int  c = 0, ndone = 0, done_cyc = -1;
        int  xcnt = 0, fcnt = 0, xerr = 0, ferr = 0, stalls = 0;
        bit  hold_x = 0, hold_f = 0;
        logic [W-1:0] px = '0, pf = '0;
        logic rx, rf;
        chk({tag, "_busy_start"}, busy, 1);
        while (c < 20000) begin
            if (done) begin
                ndone++;
                done_cyc = c;
            end
            if (!busy) break;
            if (hold_x && (m_valid_x !== 1'b1 || m_data_x !== px)) xerr++;
            if (hold_f && (m_valid_f !== 1'b1 || m_data_f !== pf)) ferr++;
            if (m_valid_x && (xcnt >= N * frames || m_data_x !== xv[xcnt % N])) xerr++;
            if (m_valid_f && (fcnt >= M * frames || m_data_f !== fv[fcnt % M])) ferr++;
            rx = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rf = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            m_ready_x = rx;
            m_ready_f = rf;
            if ((m_valid_x && !rx) || (m_valid_f && !rf)) stalls++;
            hold_x = m_valid_x && !rx;
            hold_f = m_valid_f && !rf;
            px = m_data_x;
            pf = m_data_f;
            if (m_valid_x && rx) xcnt++;
            if (m_valid_f && rf) fcnt++;
            clear = poke && (c == 10);
            start = poke && (c == 10);
            step();
            c++;
        end
        clear = 1'b0;
        start = 1'b0;
        m_ready_x = 1'b1;
        m_ready_f = 1'b1;
        chk({tag, "_timeout"}, (c >= 20000), 0);
        chk({tag, "_xcnt"}, xcnt, N * frames);
        chk({tag, "_fcnt"}, fcnt, M * frames);
        chk({tag, "_xerr"}, xerr, 0);
        chk({tag, "_ferr"}, ferr, 0);
        chk({tag, "_ndone"}, ndone, 1);
        chk({tag, "_valid_x_end"}, m_valid_x, 0);
        chk({tag, "_valid_f_end"}, m_valid_f, 0);
        if (!rnd) chk({tag, "_done_cycle"}, done_cyc, N * frames);
`ifdef CONV_FEEDER_STALL_CNT_EN
        chk({tag, "_stall_cycles"}, stall_cycles, stalls);
`endif
        step();
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) xv[i] = W'(i);
        for (int i = 0; i < M; i++) fv[i] = W'(200 - 5 * i);

        // reset state
        #2;
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid_x", m_valid_x, 0);
        chk("rst_valid_f", m_valid_f, 0);
        chk("rst_data_x", m_data_x, 0);
        chk("rst_data_f", m_data_f, 0);
        step();
        step();
        reset = 1'b1;
        step();
        chk("post_rst_ld_ready", ld_ready, 1);

        // 1: interleaved load, one frame with readies high
        for (int i = 0; i < N; i++) begin
            load_word(1'b0, xv[i]);
            if (i < M) load_word(1'b1, fv[i]);
        end
        ld_sel = 1'b0; #1; chk("full_ready_x", ld_ready, 0);
        ld_sel = 1'b1; #1; chk("full_ready_f", ld_ready, 0);
        step();
        start_pulse(1);
        run_stream("t1", 1, 0, 0);

        // 2: three frames, random back-pressure, clear/start ignored mid-stream
        start_pulse(3);
        run_stream("t2", 3, 1, 1);
        ld_sel = 1'b0; #1; chk("t2_still_loaded", ld_ready, 0);

        // 3: num_iters=0 acts as one frame; start after clear does nothing
        step();
        start_pulse(0);
        run_stream("t3", 1, 0, 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        start_pulse(1);
        chk("t3_nostart_busy", busy, 0);
        chk("t3_nostart_valid_x", m_valid_x, 0);
        chk("t3_nostart_valid_f", m_valid_f, 0);
        ld_sel = 1'b0; #1; chk("t3_cleared_ready", ld_ready, 1);

        // 4: x buffer full blocks only x words; clear beats start
        step();
        for (int i = 0; i < N; i++) load_word(1'b0, xv[i]);
        ld_sel = 1'b0; ld_valid = 1'b1; #1;
        chk("t4_x_full_ready", ld_ready, 0);
        ld_sel = 1'b1; #1;
        chk("t4_f_open_ready", ld_ready, 1);
        ld_valid = 1'b0;
        step();
        for (int i = 0; i < M; i++) load_word(1'b1, fv[i]);
        clear = 1'b1;
        start = 1'b1;
        num_iters = IW'(1);
        step();
        clear = 1'b0;
        start = 1'b0;
        chk("t4_clear_wins_busy", busy, 0);
        ld_sel = 1'b0; #1; chk("t4_clear_wins_ready", ld_ready, 1);
        step();
        for (int i = 0; i < N; i++) load_word(1'b0, xv[i]);
        for (int i = 0; i < M; i++) load_word(1'b1, fv[i]);

        // 5: reset in the middle of a frame
        start_pulse(1);
        for (int i = 0; i < 50; i++) step();
        chk("t5_at_x50", m_data_x, xv[50]);
        reset = 1'b0;
        #1;
        chk("t5_rst_valid_x", m_valid_x, 0);
        chk("t5_rst_valid_f", m_valid_f, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        step();
        chk("t5_rst_done_held", done, 0);
        reset = 1'b1;
        step();
        ld_sel = 1'b0; #1;
        chk("t5_post_ready", ld_ready, 1);
        start_pulse(1);
        chk("t5_unloaded_busy", busy, 0);
        chk("t5_unloaded_valid_x", m_valid_x, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
